// File: rtl/hex_word_serializer_if.sv
// Handshake bundle for hex_word_serializer: word input stream and ASCII character output stream.
interface hex_word_serializer_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_char;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_char
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_char
   );
endinterface

// File: rtl/hex_word_serializer.sv
// Prints a WIDTH-bit word as uppercase hex ASCII, MS nibble first, followed by a terminator.
// HEX_WORD_SERIALIZER_CRLF_EN: terminator is CR,LF instead of a single space.
module hex_word_serializer #(
   parameter int WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   hex_word_serializer_if.slave bus,
   output logic                 busy
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, DIGIT = 2'd1, TERM = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       nib;
`ifdef HEX_WORD_SERIALIZER_CRLF_EN
   logic             sub_q, sub_d;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
`ifdef HEX_WORD_SERIALIZER_CRLF_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
`ifdef HEX_WORD_SERIALIZER_CRLF_EN
         sub_q   <= sub_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
`ifdef HEX_WORD_SERIALIZER_CRLF_EN
      sub_d   = sub_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               word_d  = bus.in_data;
               cnt_d   = CW'(NIB - 1);
               state_d = DIGIT;
            end
         end
         DIGIT: begin
            if (bus.out_ready) begin
               if (cnt_q == '0) begin
                  state_d = TERM;
               end else begin
                  word_d = word_q << 4;
                  cnt_d  = cnt_q - 1'b1;
               end
            end
         end
         TERM: begin
            if (bus.out_ready) begin
`ifdef HEX_WORD_SERIALIZER_CRLF_EN
               // sub_q=0 -> CR pending, sub_q=1 -> LF pending
               if (sub_q) begin
                  sub_d   = 1'b0;
                  state_d = IDLE;
               end else begin
                  sub_d = 1'b1;
               end
`else
               state_d = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode registered state only, so nothing ripples from inputs.
   assign nib = word_q[WIDTH-1 -: 4];

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_char  = 8'h00;
      busy          = 1'b1;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            busy         = 1'b0;
         end
         DIGIT: begin
            bus.out_valid = 1'b1;
            bus.out_char  = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
         end
         TERM: begin
            bus.out_valid = 1'b1;
`ifdef HEX_WORD_SERIALIZER_CRLF_EN
            bus.out_char  = sub_q ? 8'h0A : 8'h0D;
`else
            bus.out_char  = 8'h20;
`endif
         end
         default: busy = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_hex_word_serializer.sv
// Bench for hex_word_serializer: a 32-bit and an 8-bit instance, fixed vectors plus random words.
module tb_hex_word_serializer;
   typedef byte unsigned bq_t[$];

   typedef struct {
      int          sel;     // 0: 32-bit instance, 1: 8-bit instance
      logic [31:0] data;
      int          mode;    // 0 always ready, 1 pattern 1,0,0, 2 random
      string       digits;
   } vec_t;

   logic clock = 1'b0;
   logic reset_n;
   logic busy32, busy8;
   int   checks = 0;
   int   failures = 0;

   hex_word_serializer_if #(.WIDTH(32)) b32();
   hex_word_serializer_if #(.WIDTH(8))  b8();

   hex_word_serializer #(.WIDTH(32)) dut32 (.clock(clock), .reset_n(reset_n), .bus(b32), .busy(busy32));
   hex_word_serializer #(.WIDTH(8))  dut8  (.clock(clock), .reset_n(reset_n), .bus(b8),  .busy(busy8));

   always #5 clock = ~clock;

   function automatic logic ov(int s); return s != 0 ? b8.out_valid : b32.out_valid; endfunction
   function automatic logic ir(int s); return s != 0 ? b8.in_ready : b32.in_ready; endfunction
   function automatic logic bz(int s); return s != 0 ? busy8 : busy32; endfunction
   function automatic logic [7:0] oc(int s); return s != 0 ? b8.out_char : b32.out_char; endfunction

   task automatic set_in(int s, logic v, logic [31:0] d);
      if (s != 0) begin b8.in_valid = v; b8.in_data = d[7:0]; end
      else begin b32.in_valid = v; b32.in_data = d; end
   endtask

   task automatic set_ordy(int s, logic r);
      if (s != 0) b8.out_ready = r; else b32.out_ready = r;
   endtask

   task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic void add_term(ref bq_t q);
`ifdef HEX_WORD_SERIALIZER_CRLF_EN
      q.push_back(8'h0D);
      q.push_back(8'h0A);
`else
      q.push_back(8'h20);
`endif
   endfunction

   // Reference: hex text of the word via a digit lookup, then the terminator.
   function automatic bq_t model(logic [31:0] d, int w);
      string hexd = "0123456789ABCDEF";
      bq_t q;
      for (int i = w / 4 - 1; i >= 0; i--) q.push_back(hexd[int'((d >> (4 * i)) & 32'hF)]);
      add_term(q);
      return q;
   endfunction

   function automatic bq_t str2q(string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      add_term(q);
      return q;
   endfunction

   function automatic string q2s(bq_t q);
      string s = "";
      foreach (q[i]) s = $sformatf("%s<%02h>", s, q[i]);
      return s;
   endfunction

   task automatic send(int s, logic [31:0] d, bit hold);
      int w = 0;
      @(negedge clock);
      while (!ir(s) && w < 100) begin @(negedge clock); w++; end
      check("in_ready_wait", 64'(ir(s)), 64'd1);
      set_in(s, 1'b1, d);
      @(posedge clock); #1;
      if (!hold) set_in(s, 1'b0, 32'h0);
   endtask

   // Collects n characters; when n covers the whole word also checks the bubble back to IDLE.
   task automatic recv(int s, bq_t exp, int n, int mode, string nm);
      bq_t  got;
      int   cyc = 0, stall_bad = 0, hold_bad = 0;
      logic stalled = 1'b0, rdy;
      logic [7:0] prev_c = 8'h00;
      while (got.size() < n && cyc < 200) begin
         @(negedge clock);
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(cyc % 3 == 0) : logic'($urandom_range(0, 1));
         set_ordy(s, rdy);
         if (stalled && (!ov(s) || oc(s) != prev_c)) stall_bad++;
         if (!ov(s) || !bz(s) || ir(s)) hold_bad++;
         stalled = ov(s) && !rdy;
         prev_c  = oc(s);
         if (ov(s) && rdy) got.push_back(oc(s));
         cyc++;
      end
      checks++;
      if (got.size() != n || got != exp[0:n-1]) begin
         failures++;
         $display("FAIL %s chars: got %s expected %s", nm, q2s(got), q2s(exp[0:n-1]));
      end
      check({nm, " stall_stable"}, 64'(stall_bad), 64'd0);
      check({nm, " valid_busy_hold"}, 64'(hold_bad), 64'd0);
      if (mode == 0) check({nm, " one_per_cycle"}, 64'(cyc), 64'(n));
      if (n == exp.size()) begin
         @(negedge clock);
         check({nm, " end_state"}, {61'd0, ov(s), ir(s), bz(s)}, 64'b010);
      end
   endtask

   initial begin
      vec_t tbl[$];
      bq_t  e;
      int   bad;
      tbl.push_back('{0, 32'h1234ABCF, 0, "1234ABCF"});
      tbl.push_back('{0, 32'h00000000, 0, "00000000"});
      tbl.push_back('{0, 32'hDEADBEEF, 1, "DEADBEEF"});
      tbl.push_back('{0, 32'hFFFFFFFF, 2, "FFFFFFFF"});
      tbl.push_back('{0, 32'h0F1E2D3C, 1, "0F1E2D3C"});
      tbl.push_back('{1, 32'h0000007F, 0, "7F"});
      tbl.push_back('{1, 32'h000000A0, 1, "A0"});

      reset_n = 1'b0;
      set_in(0, 1'b0, 32'h0);
      set_in(1, 1'b0, 32'h0);
      set_ordy(0, 1'b0);
      set_ordy(1, 1'b0);
      repeat (2) @(negedge clock);
      check("reset32", {ov(0), ir(0), bz(0), oc(0)}, {3'b010, 8'h00});
      check("reset8",  {ov(1), ir(1), bz(1), oc(1)}, {3'b010, 8'h00});
      reset_n = 1'b1;

      foreach (tbl[i]) begin
         send(tbl[i].sel, tbl[i].data, 1'b0);
         recv(tbl[i].sel, str2q(tbl[i].digits), str2q(tbl[i].digits).size(), tbl[i].mode,
              $sformatf("vec%0d", i));
      end

      // Input held valid while busy must wait for IDLE.
      send(0, 32'h00000001, 1'b0);
      set_in(0, 1'b1, 32'hFFFFFFFF);
      e = model(32'h00000001, 32);
      recv(0, e, e.size(), 0, "busy_in_first");
      @(posedge clock); #1;
      set_in(0, 1'b0, 32'h0);
      e = model(32'hFFFFFFFF, 32);
      recv(0, e, e.size(), 0, "busy_in_second");

      // Reset mid-word abandons the remaining digits.
      send(0, 32'h89ABCDEF, 1'b0);
      e = model(32'h89ABCDEF, 32);
      recv(0, e, 3, 0, "rst_mid");
      @(posedge clock); #2;
      reset_n = 1'b0;
      #1;
      check("rst_async", {ov(0), bz(0), oc(0)}, {2'b00, 8'h00});
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      bad = 0;
      set_ordy(0, 1'b1);
      repeat (4) begin
         @(negedge clock);
         if (ov(0) || !ir(0)) bad++;
      end
      check("rst_no_leftover", 64'(bad), 64'd0);
      send(0, 32'h0000000A, 1'b0);
      recv(0, str2q("0000000A"), str2q("0000000A").size(), 0, "after_rst");

      for (int k = 0; k < 20; k++) begin
         int          s = int'($urandom_range(0, 1));
         logic [31:0] d = $urandom;
         if (s != 0) d = d & 32'hFF;
         e = model(d, (s != 0) ? 8 : 32);
         send(s, d, 1'b0);
         recv(s, e, e.size(), 2, $sformatf("rnd%0d", k));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
